// File: rtl/wb_port_arbiter_pkg.sv
// Shared widths and types for the register-file write-port arbiter.
// Holds the RF address width and XLEN beside the grant encoding.
package wb_port_arbiter_pkg;

  localparam int RF_AW = 5;
  localparam int XLEN  = 32;

  typedef struct packed {
    logic [RF_AW-1:0] rd;
    logic [XLEN-1:0]  data;
  } wb_res_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_WB,
    GNT_FIFO,
    GNT_LU
  } gnt_e;

endpackage

// File: rtl/wb_result_fifo.sv
// DEPTH x 37-bit result FIFO for long-latency unit write-backs.
// Caller never pushes when full nor pops when empty.
module wb_result_fifo
  import wb_port_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  wb_res_t                i_data,
  input  logic                   i_pop,
  output wb_res_t                o_head,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  wb_res_t       r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0]   r_count;

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wp] <= i_data;
  end

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wp <= r_wp + 1'b1;
      if (i_pop)  r_rp <= r_rp + 1'b1;
      if (i_push && !i_pop)
        r_count <= r_count + 1'b1;
      else if (!i_push && i_pop)
        r_count <= r_count - 1'b1;
    end
  end

  assign o_head  = r_mem[r_rp];
  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the RF write port between WB and buffered long-unit results.
// Build option: WB_ARB_BYPASS_EN writes an idle-port LU result directly.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wb_we,
  input  logic [4:0]             wb_rd,
  input  logic [31:0]            wb_data,
  input  logic                   lu_valid,
  input  logic [4:0]             lu_rd,
  input  logic [31:0]            lu_data,
  output logic                   lu_ready,
  output logic                   stall_wb,
  output logic                   rf_we,
  output logic [4:0]             rf_rd,
  output logic [31:0]            rf_wd,
  output logic [$clog2(DEPTH):0] lu_pending
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = STARVE_LIMIT[SW-1:0];

  wb_res_t       w_head;
  wb_res_t       w_lu;
  wb_res_t       w_wb;
  wb_res_t       w_sel;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_starved;
  gnt_e          w_gnt;
  logic [SW-1:0] r_starve;
  logic          r_rf_we;
  logic [4:0]    r_rf_rd;
  logic [31:0]   r_rf_wd;

  assign w_lu      = '{rd: lu_rd, data: lu_data};
  assign w_wb      = '{rd: wb_rd, data: wb_data};
  assign w_starved = (r_starve == STARVE_MAX);

  always_comb begin
    w_gnt = GNT_NONE;
    if (!w_empty && (!wb_we || w_full || w_starved))
      w_gnt = GNT_FIFO;
    else if (wb_we)
      w_gnt = GNT_WB;
`ifdef WB_ARB_BYPASS_EN
    else if (lu_valid && w_empty)
      w_gnt = GNT_LU;
`endif
  end

  always_comb begin
    w_sel = w_wb;
    unique case (w_gnt)
      GNT_FIFO: w_sel = w_head;
      GNT_LU:   w_sel = w_lu;
      GNT_WB:   w_sel = w_wb;
      GNT_NONE: w_sel = w_wb;
    endcase
  end

  // No pop bypass: a full FIFO refuses a push even while popping.
  assign w_pop    = (w_gnt == GNT_FIFO);
  assign w_push   = lu_valid && !w_full && (w_gnt != GNT_LU);
  assign lu_ready = !w_full;
  assign stall_wb = wb_we && w_pop;

  wb_result_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_lu),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (lu_pending)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rf_we  <= 1'b0;
      r_rf_rd  <= '0;
      r_rf_wd  <= '0;
      r_starve <= '0;
    end else begin
      r_rf_we <= 1'b0;
      if (w_gnt != GNT_NONE) begin
        r_rf_we <= |w_sel.rd;
        r_rf_rd <= w_sel.rd;
        r_rf_wd <= w_sel.data;
      end
      if (w_empty || w_pop)
        r_starve <= '0;
      else if (w_gnt == GNT_WB && !w_starved)
        r_starve <= r_starve + 1'b1;
    end
  end

  assign rf_we = r_rf_we;
  assign rf_rd = r_rf_rd;
  assign rf_wd = r_rf_wd;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed vector table, reset sequence,
// then random traffic against a queue-based reference model.
module tb_wb_port_arbiter;

  localparam int DEPTH = 2;
  localparam int LIM   = 4;
`ifdef WB_ARB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        lu_valid;
  logic [4:0]  lu_rd;
  logic [31:0] lu_data;
  logic        lu_ready;
  logic        stall_wb;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wd;
  logic [1:0]  lu_pending;

  always #5 clk = ~clk;

  wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIM)) dut (
    .clk        (clk),
    .rst        (rst),
    .wb_we      (wb_we),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .lu_valid   (lu_valid),
    .lu_rd      (lu_rd),
    .lu_data    (lu_data),
    .lu_ready   (lu_ready),
    .stall_wb   (stall_wb),
    .rf_we      (rf_we),
    .rf_rd      (rf_rd),
    .rf_wd      (rf_wd),
    .lu_pending (lu_pending)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [4:0]  wrd;
    logic [31:0] wd;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ld;
    logic        e_stall;
    logic        e_ready;
    logic        e_we;
    logic [4:0]  e_rd;
    logic [31:0] e_wd;
    logic [1:0]  e_pend;
    bit          chk_addr;
  } vec_t;

  vec_t tbl[18];

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] d;
  } ent_t;

  ent_t        q[$];
  int          starve;
  logic        m_we;
  logic [4:0]  m_rd;
  logic [31:0] m_wd;

  task automatic set_in(input logic we, input logic [4:0] wrd,
                        input logic [31:0] wd, input logic lv,
                        input logic [4:0] lrd, input logic [31:0] ld);
    wb_we    = we;
    wb_rd    = wrd;
    wb_data  = wd;
    lu_valid = lv;
    lu_rd    = lrd;
    lu_data  = ld;
  endtask

  // Reference model: one arbitration cycle, derived from the grant rules.
  task automatic rand_cycle();
    bit   full, req, gf, gw, gl;
    ent_t e;
    set_in($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)),
           $urandom, $urandom_range(0, 1) == 1,
           5'($urandom_range(0, 3)), $urandom);
    req  = q.size() != 0;
    full = q.size() == DEPTH;
    gf   = req && (!wb_we || full || starve == LIM);
    gw   = !gf && wb_we;
    gl   = BYP && !req && !wb_we && lu_valid;
    #4;
    chk("rnd lu_ready", lu_ready, !full);
    chk("rnd stall_wb", stall_wb, wb_we && gf);
    @(posedge clk);
    if (gf) begin
      e      = q.pop_front();
      m_we   = e.rd != 0;
      m_rd   = e.rd;
      m_wd   = e.d;
      starve = 0;
    end else if (gw) begin
      m_we = wb_rd != 0;
      m_rd = wb_rd;
      m_wd = wb_data;
      if (req && starve < LIM) starve++;
    end else if (gl) begin
      m_we = lu_rd != 0;
      m_rd = lu_rd;
      m_wd = lu_data;
    end else begin
      m_we = 1'b0;
    end
    if (!req) starve = 0;
    if (lu_valid && !full && !gl) q.push_back('{rd: lu_rd, d: lu_data});
    #1;
    chk("rnd rf_we", rf_we, m_we);
    if (m_we) begin
      chk("rnd rf_rd", rf_rd, m_rd);
      chk("rnd rf_wd", rf_wd, m_wd);
    end
    chk("rnd lu_pending", lu_pending, q.size());
  endtask

  initial begin
    tbl[0]  = '{1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'h0,
                1'b0, 1'b1, 1'b1, 5'd5, 32'h1234, 2'd0, 1'b1};
    tbl[1]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'hAA,
                1'b0, 1'b1, BYP, BYP ? 5'd7 : 5'd5,
                BYP ? 32'hAA : 32'h1234, BYP ? 2'd0 : 2'd1, 1'b1};
    tbl[2]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                1'b0, 1'b1, !BYP, 5'd7, 32'hAA, 2'd0, 1'b1};
    tbl[3]  = '{1'b1, 5'd1, 32'h11, 1'b1, 5'd9, 32'h99,
                1'b0, 1'b1, 1'b1, 5'd1, 32'h11, 2'd1, 1'b1};
    tbl[4]  = '{1'b1, 5'd2, 32'h22, 1'b0, 5'd0, 32'h0,
                1'b0, 1'b1, 1'b1, 5'd2, 32'h22, 2'd1, 1'b1};
    tbl[5]  = '{1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'h0,
                1'b0, 1'b1, 1'b1, 5'd3, 32'h33, 2'd1, 1'b1};
    tbl[6]  = '{1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 32'h0,
                1'b0, 1'b1, 1'b1, 5'd4, 32'h44, 2'd1, 1'b1};
    tbl[7]  = '{1'b1, 5'd5, 32'h55, 1'b0, 5'd0, 32'h0,
                1'b0, 1'b1, 1'b1, 5'd5, 32'h55, 2'd1, 1'b1};
    tbl[8]  = '{1'b1, 5'd6, 32'h66, 1'b0, 5'd0, 32'h0,
                1'b1, 1'b1, 1'b1, 5'd9, 32'h99, 2'd0, 1'b1};
    tbl[9]  = '{1'b1, 5'd6, 32'h66, 1'b0, 5'd0, 32'h0,
                1'b0, 1'b1, 1'b1, 5'd6, 32'h66, 2'd0, 1'b1};
    tbl[10] = '{1'b1, 5'd3, 32'h33, 1'b1, 5'd10, 32'hA0,
                1'b0, 1'b1, 1'b1, 5'd3, 32'h33, 2'd1, 1'b1};
    tbl[11] = '{1'b1, 5'd4, 32'h44, 1'b1, 5'd11, 32'hB0,
                1'b0, 1'b1, 1'b1, 5'd4, 32'h44, 2'd2, 1'b1};
    tbl[12] = '{1'b1, 5'd4, 32'h44, 1'b1, 5'd12, 32'hC0,
                1'b1, 1'b0, 1'b1, 5'd10, 32'hA0, 2'd1, 1'b1};
    tbl[13] = '{1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 32'h0,
                1'b0, 1'b1, 1'b1, 5'd4, 32'h44, 2'd1, 1'b1};
    tbl[14] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hDEAD,
                1'b0, 1'b1, 1'b1, 5'd11, 32'hB0, 2'd1, 1'b1};
    tbl[15] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 2'd0, 1'b0};
    tbl[16] = '{1'b1, 5'd0, 32'h55, 1'b0, 5'd0, 32'h0,
                1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 2'd0, 1'b0};
    tbl[17] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 2'd0, 1'b0};

    rst = 1'b1;
    set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #1;
    chk("reset rf_we", rf_we, 1'b0);
    chk("reset rf_rd", rf_rd, 5'd0);
    chk("reset rf_wd", rf_wd, 32'h0);
    chk("reset lu_pending", lu_pending, 2'd0);
    chk("reset lu_ready", lu_ready, 1'b1);
    chk("reset stall_wb", stall_wb, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    foreach (tbl[i]) begin
      set_in(tbl[i].we, tbl[i].wrd, tbl[i].wd,
             tbl[i].lv, tbl[i].lrd, tbl[i].ld);
      #4;
      chk($sformatf("vec%0d stall_wb", i), stall_wb, tbl[i].e_stall);
      chk($sformatf("vec%0d lu_ready", i), lu_ready, tbl[i].e_ready);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d rf_we", i), rf_we, tbl[i].e_we);
      chk($sformatf("vec%0d lu_pending", i), lu_pending, tbl[i].e_pend);
      if (tbl[i].chk_addr) begin
        chk($sformatf("vec%0d rf_rd", i), rf_rd, tbl[i].e_rd);
        chk($sformatf("vec%0d rf_wd", i), rf_wd, tbl[i].e_wd);
      end
    end

    // Mid-run reset with two results buffered.
    set_in(1'b1, 5'd1, 32'h1, 1'b1, 5'd20, 32'h200);
    @(posedge clk);
    #1;
    set_in(1'b1, 5'd2, 32'h2, 1'b1, 5'd21, 32'h210);
    @(posedge clk);
    #1;
    chk("pre-rst lu_pending", lu_pending, 2'd2);
    chk("pre-rst rf_we", rf_we, 1'b1);
    #2 rst = 1'b1;
    set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #1;
    chk("mid-rst rf_we", rf_we, 1'b0);
    chk("mid-rst lu_pending", lu_pending, 2'd0);
    chk("mid-rst lu_ready", lu_ready, 1'b1);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #4;
      chk("post-rst stall_wb", stall_wb, 1'b0);
      @(posedge clk);
      #1;
      chk("post-rst rf_we", rf_we, 1'b0);
      chk("post-rst lu_pending", lu_pending, 2'd0);
    end

    q.delete();
    starve = 0;
    m_we   = 1'b0;
    m_rd   = 5'd0;
    m_wd   = 32'h0;
    for (int n = 0; n < 3000; n++) rand_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
Arbitrates the single register-file write port between the in-order WB stage and a long-latency execution unit (mul/div, future LSU miss path) that returns results out of band. Long-unit results are buffered in a small FIFO. The block either grants the port to the FIFO head and stalls WB, or lets WB write. Sits between wb_stage (data_to_reg) and the register file write port.

Parameters:
DEPTH, 2, long-unit result FIFO entries (power of two, 2..8)
STARVE_LIMIT, 4, consecutive denied cycles after which the FIFO head wins over a WB write

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
wb_we  in  1  WB stage requests a register write this cycle
wb_rd  in  5  WB destination register
wb_data  in  32  WB write data (data_to_reg)
lu_valid  in  1  long unit presents a result
lu_rd  in  5  long-unit destination register
lu_data  in  32  long-unit result
lu_ready  out  1  FIFO can accept; a push happens iff lu_valid && lu_ready
stall_wb  out  1  WB write denied this cycle; pipeline must hold WB contents
rf_we  out  1  registered register-file write enable
rf_rd  out  5  registered write address
rf_wd  out  32  registered write data
lu_pending  out  $clog2(DEPTH)+1  FIFO occupancy, for hazard unit

Behaviour:
- Reset (async, immediate): FIFO empty, lu_pending=0, rf_we=0, rf_rd=0, rf_wd=0, starve counter=0. lu_ready=1 and stall_wb=0 once rst deasserts.
- lu_ready = !full. It is a pure occupancy function: no same-cycle pop bypass, so a full FIFO refuses a push even if it pops that cycle.
- Grant decision (combinational, per cycle). Let fifo_req = !empty.
  - fifo_req && (!wb_we || full || starve==STARVE_LIMIT) -> grant FIFO: pop head.
  - Otherwise, if wb_we -> grant WB.
  - Otherwise -> no write.
- stall_wb = wb_we && grant FIFO. It is combinational, valid in the same cycle.
- Write port latency is 1 cycle. On the clk edge after a grant: rf_we=1, rf_rd/rf_wd = the granted source.
  - Exception: a granted write with rd==0 still pops or consumes, but rf_we=0.
  - With no grant: rf_we=0; rf_rd and rf_wd hold their previous values.
- Starve counter:
  - Increments (saturating at STARVE_LIMIT) when fifo_req and WB is granted.
  - Clears on a FIFO grant or when the FIFO is empty.
- A push and a pop in the same cycle leave occupancy unchanged. Pointers wrap modulo DEPTH.
- WAW ordering between WB and FIFO for the same rd is the hazard unit's responsibility; this block does not check it.
- Reset mid-operation discards all buffered results. Nothing is written after reset.

Optional Feature:
WB_ARB_BYPASS_EN
- Defined: when the FIFO is empty, lu_valid=1 and wb_we=0, the long-unit result is granted directly. It is written on the next edge without entering the FIFO, so lu_pending does not change.
- Undefined: every long-unit result passes through the FIFO, giving a minimum of 2 cycles from lu_valid to rf_we.

Decomposition:
- Shared package/constants file: RF address width (5) and XLEN (32); these belong next to the existing opcode constants.
- One natural sub-module, wb_result_fifo: a parameterised DEPTH x 37-bit synchronous FIFO with async reset, push/pop, full/empty and count.
- Arbitration and the starve counter stay in the top module.

Test Plan:
- Reset: assert rst mid-run with 2 entries buffered -> rf_we=0, lu_pending=0, lu_ready=1 immediately; nothing written afterwards.
- WB only: wb_we=1, wb_rd=5, wb_data=0x1234 -> next edge rf_we=1, rf_rd=5, rf_wd=0x1234; stall_wb=0.
- Idle port: push lu_rd=7, data=0xAA with wb_we=0 -> stored, then granted next cycle. rf_we=1, rf_rd=7 two edges after the push (bypass off) or one edge (bypass on).
- Starvation: FIFO holds 1 entry, wb_we=1 continuously -> WB wins 4 cycles, 5th cycle stall_wb=1 and FIFO written; counter clears.
- Full FIFO: DEPTH=2, fill both with wb_we=1 -> lu_ready=0, FIFO granted immediately (full overrides), stall_wb=1; lu_ready returns to 1 the cycle after the pop.
- rd=0: push lu_rd=0 -> entry pops, lu_pending decrements, rf_we stays 0.
